// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file access arbiter.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_e;

    localparam logic PORT_CMD = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    // Smallest width able to count 0 .. value-1.
    function automatic int clog2(input int unsigned value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: one-hot select of the requesting port, alternating on contention.
module rr_arb2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       update,
    output logic [1:0] sel
);
    import rf_arb_pkg::*;

    logic prio_r;

    // Port favoured on contention: the one not granted most recently.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prio_r <= PORT_CMD;
        end else if (update) begin
            prio_r <= ~last_gnt;
        end else begin
            prio_r <= prio_r;
        end
    end

    // One-hot selection from the current requests.
    always_comb begin
        sel = 2'b00;
        case (req)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            2'b11:   sel = (prio_r == PORT_DBG) ? 2'b10 : 2'b01;
            default: sel = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one register-file port between the command controller (port 0) and the
// config/debug master (port 1); one op outstanding, bounded read wait.
module rf_access_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0_VLD,
    input  logic                  REQ0_WR,
    input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
    output logic                  REQ0_RDY,
    output logic [DATA_WIDTH-1:0] RSP0_DATA,
    output logic                  RSP0_VLD,
    input  logic                  REQ1_VLD,
    input  logic                  REQ1_WR,
    input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
    input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
    output logic                  REQ1_RDY,
    output logic [DATA_WIDTH-1:0] RSP1_DATA,
    output logic                  RSP1_VLD,
    output logic [ADDR_WIDTH-1:0] RF_Address,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [DATA_WIDTH-1:0] RF_WrData,
    input  logic [DATA_WIDTH-1:0] RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic                  RD_TOUT
);
    import rf_arb_pkg::*;

    localparam int TMR_W = (clog2(RD_TIMEOUT) < 1) ? 1 : clog2(RD_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RD_TIMEOUT - 1);

    arb_state_e            state_r, state_s;
    logic                  owner_r, owner_s;
    logic                  wr_r, wr_s;
    logic [TMR_W-1:0]      tmr_r, tmr_s;
    logic [1:0]            req_s, sel_s;
    logic                  idle_s, accept_s, gnt_port_s;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] wdata_s, rsp0_data_s, rsp1_data_s, rd_val_s;
    logic                  wren_s, rden_s, tout_s;
    logic [1:0]            rsp_vld_s;

    assign req_s      = {REQ1_VLD, REQ0_VLD};
    assign idle_s     = (state_r == IDLE);
    assign gnt_port_s = sel_s[1];
    // Ready is held low while reset is applied so no op can slip in.
    assign REQ0_RDY   = RST & idle_s & sel_s[0];
    assign REQ1_RDY   = RST & idle_s & sel_s[1];
    assign accept_s   = REQ0_RDY | REQ1_RDY;

    rr_arb2 u_rr_arb2 (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req_s),
        .last_gnt (gnt_port_s),
        .update   (accept_s),
        .sel      (sel_s)
    );

    // Next-state and next-output computation for the access FSM.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        wr_s        = wr_r;
        tmr_s       = tmr_r;
        addr_s      = RF_Address;
        wdata_s     = RF_WrData;
        wren_s      = 1'b0;
        rden_s      = 1'b0;
        rsp_vld_s   = 2'b00;
        rsp0_data_s = RSP0_DATA;
        rsp1_data_s = RSP1_DATA;
        tout_s      = 1'b0;
        rd_val_s    = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    owner_s = gnt_port_s;
                    if (gnt_port_s == PORT_DBG) begin
                        wr_s    = REQ1_WR;
                        addr_s  = REQ1_ADDR;
                        wdata_s = REQ1_WDATA;
                    end else begin
                        wr_s    = REQ0_WR;
                        addr_s  = REQ0_ADDR;
                        wdata_s = REQ0_WDATA;
                    end
                    wren_s  = wr_s;
                    rden_s  = ~wr_s;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                tmr_s = {TMR_W{1'b0}};
                if (wr_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_RD;
                end
            end
            WAIT_RD: begin
                // Data in the final timer cycle still wins over the timeout.
                if (RF_RdData_VLD || (tmr_r == TMR_LAST)) begin
                    state_s = IDLE;
                    tout_s  = ~RF_RdData_VLD;
                    if (RF_RdData_VLD) begin
                        rd_val_s = RF_RdData;
                    end else begin
                        rd_val_s = {DATA_WIDTH{1'b0}};
                    end
                    if (owner_r == PORT_DBG) begin
                        rsp_vld_s   = 2'b10;
                        rsp1_data_s = rd_val_s;
                    end else begin
                        rsp_vld_s   = 2'b01;
                        rsp0_data_s = rd_val_s;
                    end
                end else begin
                    tmr_s = tmr_r + TMR_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r    <= IDLE;
            owner_r    <= PORT_CMD;
            wr_r       <= 1'b0;
            tmr_r      <= {TMR_W{1'b0}};
            RF_Address <= {ADDR_WIDTH{1'b0}};
            RF_WrData  <= {DATA_WIDTH{1'b0}};
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RSP0_VLD   <= 1'b0;
            RSP1_VLD   <= 1'b0;
            RSP0_DATA  <= {DATA_WIDTH{1'b0}};
            RSP1_DATA  <= {DATA_WIDTH{1'b0}};
            RD_TOUT    <= 1'b0;
        end else begin
            state_r    <= state_s;
            owner_r    <= owner_s;
            wr_r       <= wr_s;
            tmr_r      <= tmr_s;
            RF_Address <= addr_s;
            RF_WrData  <= wdata_s;
            RF_WrEn    <= wren_s;
            RF_RdEn    <= rden_s;
            RSP0_VLD   <= rsp_vld_s[0];
            RSP1_VLD   <= rsp_vld_s[1];
            RSP0_DATA  <= rsp0_data_s;
            RSP1_DATA  <= rsp1_data_s;
            RD_TOUT    <= tout_s;
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Randomised scoreboard bench for rf_access_arbiter with a transaction-timing reference model.
module tb_rf_access_arbiter;
    localparam int RD_TIMEOUT = 16;

    typedef struct { logic wr; logic [3:0] addr; logic [7:0] data; int lat; int gap; } op_t;
    typedef struct { int cyc; logic wr; logic [3:0] addr; logic [7:0] data; } rf_exp_t;
    typedef struct { int cyc; int port; logic [7:0] data; logic tout; } rsp_exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       REQ0_VLD = 1'b0, REQ0_WR = 1'b0, REQ1_VLD = 1'b0, REQ1_WR = 1'b0;
    logic [3:0] REQ0_ADDR = 4'h0, REQ1_ADDR = 4'h0;
    logic [7:0] REQ0_WDATA = 8'h00, REQ1_WDATA = 8'h00;
    logic       REQ0_RDY, REQ1_RDY, RSP0_VLD, RSP1_VLD;
    logic [7:0] RSP0_DATA, RSP1_DATA;
    logic [3:0] RF_Address;
    logic       RF_WrEn, RF_RdEn, RD_TOUT;
    logic [7:0] RF_WrData;
    logic [7:0] RF_RdData = 8'h00;
    logic       RF_RdData_VLD = 1'b0;

    rf_access_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VLD(REQ0_VLD), .REQ0_WR(REQ0_WR), .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ0_RDY(REQ0_RDY), .RSP0_DATA(RSP0_DATA), .RSP0_VLD(RSP0_VLD),
        .REQ1_VLD(REQ1_VLD), .REQ1_WR(REQ1_WR), .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .REQ1_RDY(REQ1_RDY), .RSP1_DATA(RSP1_DATA), .RSP1_VLD(RSP1_VLD),
        .RF_Address(RF_Address), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD), .RD_TOUT(RD_TOUT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    op_t      q0[$], q1[$];
    rf_exp_t  rf_q[$];
    rsp_exp_t rsp_q[$];
    int       lat_q[$];
    logic [7:0] shadow [16];
    logic [7:0] rf_mem [16];
    logic [7:0] exp_hold [2];
    logic [1:0] exp_rdy = 2'b00;
    logic [7:0] vld_data = 8'h00;
    int  free_at = 0, last = 1, vld_at = -1;
    int  errors = 0, checks = 0;
    bit  mon_en = 1'b0, skip_hold = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected RF strobes and responses when the DUT presents them.
    always @(negedge CLK) begin
        if (mon_en) begin
            rf_exp_t  re;
            rsp_exp_t rs;
            check("req0_rdy", REQ0_RDY, exp_rdy[0]);
            check("req1_rdy", REQ1_RDY, exp_rdy[1]);
            if (RF_WrEn || RF_RdEn) begin
                if (rf_q.size() == 0) check("rf_strobe_unexpected", {RF_WrEn, RF_RdEn}, 0);
                else begin
                    re = rf_q.pop_front();
                    check("rf_strobe_cycle", cyc, re.cyc);
                    check("rf_strobes", {RF_WrEn, RF_RdEn}, re.wr ? 2'b10 : 2'b01);
                    check("rf_address", RF_Address, re.addr);
                    if (re.wr) check("rf_wrdata", RF_WrData, re.data);
                end
            end
            if (RSP0_VLD || RSP1_VLD) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", {RSP1_VLD, RSP0_VLD}, 0);
                else begin
                    rs = rsp_q.pop_front();
                    check("rsp_cycle", cyc, rs.cyc);
                    check("rsp_vld", {RSP1_VLD, RSP0_VLD}, (rs.port == 1) ? 2'b10 : 2'b01);
                    check("rsp_data", (rs.port == 1) ? RSP1_DATA : RSP0_DATA, rs.data);
                    check("rd_tout", RD_TOUT, rs.tout);
                    exp_hold[rs.port] = rs.data;
                end
            end else begin
                check("rd_tout_idle", RD_TOUT, 0);
            end
            if (!skip_hold) begin
                check("rsp0_data_hold", RSP0_DATA, exp_hold[0]);
                check("rsp1_data_hold", RSP1_DATA, exp_hold[1]);
            end
        end
    end

    // One clock of environment: RF responder, both requesters and the reference model.
    task automatic step();
        int g;
        int lat;
        op_t op;
        rf_exp_t re;
        rsp_exp_t rs;
        @(posedge CLK); #1;
        RF_RdData_VLD = 1'b0;
        RF_RdData = 8'($urandom);
        if (RF_WrEn) rf_mem[RF_Address] = RF_WrData;
        if (RF_RdEn && lat_q.size() > 0) begin
            lat = lat_q.pop_front();
            if (lat > 0) begin
                vld_at = cyc + lat;
                vld_data = rf_mem[RF_Address];
            end
            RF_RdData_VLD = 1'($urandom_range(0, 1));
        end
        if (cyc == vld_at) begin
            RF_RdData_VLD = 1'b1;
            RF_RdData = vld_data;
        end
        if (q0.size() > 0 && q0[0].gap == 0) begin
            REQ0_VLD = 1'b1; REQ0_WR = q0[0].wr; REQ0_ADDR = q0[0].addr; REQ0_WDATA = q0[0].data;
        end else begin
            REQ0_VLD = 1'b0; REQ0_WR = 1'($urandom); REQ0_ADDR = 4'($urandom); REQ0_WDATA = 8'($urandom);
            if (q0.size() > 0) begin op = q0[0]; op.gap--; q0[0] = op; end
        end
        if (q1.size() > 0 && q1[0].gap == 0) begin
            REQ1_VLD = 1'b1; REQ1_WR = q1[0].wr; REQ1_ADDR = q1[0].addr; REQ1_WDATA = q1[0].data;
        end else begin
            REQ1_VLD = 1'b0; REQ1_WR = 1'($urandom); REQ1_ADDR = 4'($urandom); REQ1_WDATA = 8'($urandom);
            if (q1.size() > 0) begin op = q1[0]; op.gap--; q1[0] = op; end
        end
        exp_rdy = 2'b00;
        if (cyc >= free_at && (REQ0_VLD || REQ1_VLD)) begin
            if (REQ0_VLD && REQ1_VLD) g = 1 - last;
            else if (REQ1_VLD) g = 1;
            else g = 0;
            exp_rdy[g] = 1'b1;
            last = g;
            if (g == 1) op = q1.pop_front(); else op = q0.pop_front();
            re.cyc = cyc + 1; re.wr = op.wr; re.addr = op.addr; re.data = op.data;
            rf_q.push_back(re);
            if (op.wr) begin
                shadow[op.addr] = op.data;
                free_at = cyc + 2;
            end else begin
                lat_q.push_back(op.lat);
                rs.port = g;
                if (op.lat >= 1 && op.lat <= RD_TIMEOUT) begin
                    rs.cyc = cyc + 2 + op.lat; rs.data = shadow[op.addr]; rs.tout = 1'b0;
                end else begin
                    rs.cyc = cyc + 2 + RD_TIMEOUT; rs.data = 8'h00; rs.tout = 1'b1;
                end
                free_at = rs.cyc;
                rsp_q.push_back(rs);
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at || rf_q.size() > 0 || rsp_q.size() > 0)
               && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) check("run_budget_expired", 1, 0);
    endtask

    task automatic do_reset(input int n, output int rel);
        q0.delete(); q1.delete(); rf_q.delete(); rsp_q.delete(); lat_q.delete();
        vld_at = -1;
        skip_hold = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            RST = 1'b0; REQ0_VLD = 1'b0; REQ1_VLD = 1'b0; RF_RdData_VLD = 1'b0;
            exp_rdy = 2'b00;
        end
        @(negedge CLK);
        check("rst_outputs_a", {RF_Address, RF_WrData, RF_WrEn, RF_RdEn, RD_TOUT, REQ0_RDY, REQ1_RDY}, 0);
        check("rst_outputs_b", {RSP0_DATA, RSP0_VLD, RSP1_DATA, RSP1_VLD}, 0);
        @(posedge CLK); #1;
        RST = 1'b1;
        exp_hold[0] = 8'h00; exp_hold[1] = 8'h00;
        skip_hold = 1'b0;
        last = 1;
        rel = cyc;
        free_at = cyc + 1;
    endtask

    function automatic op_t mk(input logic wr, input logic [3:0] a, input logic [7:0] d,
                               input int lat, input int gap);
        op_t o;
        o.wr = wr; o.addr = a; o.data = d; o.lat = lat; o.gap = gap;
        return o;
    endfunction

    function automatic op_t rand_op();
        int lat;
        case ($urandom_range(0, 9))
            0: lat = 0;
            1: lat = RD_TIMEOUT;
            2: lat = RD_TIMEOUT + 1;
            default: lat = int'($urandom_range(1, 4));
        endcase
        return mk(1'($urandom), 4'($urandom), 8'($urandom), lat, int'($urandom_range(0, 3)));
    endfunction

    initial begin
        int rel;
        for (int i = 0; i < 16; i++) begin
            shadow[i] = (i == 2) ? 8'hC3 : 8'(8'h10 + i);
            rf_mem[i] = shadow[i];
        end
        exp_hold[0] = 8'h00; exp_hold[1] = 8'h00;
        do_reset(3, rel);
        mon_en = 1'b1;

        q0.push_back(mk(1'b1, 4'h3, 8'h5A, 0, 0));
        run_until_idle(100);
        q1.push_back(mk(1'b0, 4'h2, 8'h00, 1, 0));
        run_until_idle(100);

        do_reset(2, rel);
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b1, 4'(4 + i), 8'(8'hA0 + i), 0, 0));
            q1.push_back(mk(1'b1, 4'(8 + i), 8'(8'hB0 + i), 0, 0));
        end
        run_until_idle(100);

        q0.push_back(mk(1'b0, 4'h5, 8'h00, 0, 0));
        q0.push_back(mk(1'b1, 4'h6, 8'h66, 0, 0));
        run_until_idle(100);

        q0.push_back(mk(1'b0, 4'h4, 8'h00, 2, 0));
        q1.push_back(mk(1'b1, 4'h9, 8'h99, 0, 1));
        run_until_idle(100);

        q0.push_back(mk(1'b0, 4'h7, 8'h00, 0, 0));
        while (q0.size() > 0) step();
        for (int i = 0; i < 4; i++) step();
        do_reset(2, rel);
        vld_at = rel + 2;
        vld_data = 8'hEE;
        q0.push_back(mk(1'b1, 4'h1, 8'h11, 0, 0));
        run_until_idle(100);

        for (int i = 0; i < 40; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        run_until_idle(5000);
        for (int i = 0; i < 4; i++) step();

        check("rf_q_drained", rf_q.size(), 0);
        check("rsp_q_drained", rsp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
